fft_frame_arbiter: RTL and testbench
====================================

# fft_frame_arbiter

Frame-level arbiter that shares one radix-2² SDF FFT pipeline between two sample sources. It grants whole N-sample frames in round-robin order and drives a contiguous `idata_en` burst into the pipeline. It then tags each output frame with the channel that produced it, using a small in-flight tag FIFO. The block sits directly in front of the first SDF stage and directly behind the last one.

## Interface
- `N`, 64, FFT points per frame (power of 2, ≥4)
- `WIDTH`, 16, sample width per component
- `GAP`, 0, minimum idle cycles forced between frames (0 = back-to-back allowed)
- `TAG_DEPTH`, 4, maximum frames in flight (power of 2)

Ports:
- `clock`  in  1  master clock
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  2  frame request per channel; high = channel holds a full frame ready
- `grant`  out  2  one-hot; channel k must present one sample per cycle while `grant[k]`=1
- `ch0_data_r`, `ch0_data_i`, `ch1_data_r`, `ch1_data_i`  in  WIDTH  channel samples
- `fft_idata_en`  out  1  to pipeline `idata_en`
- `fft_idata_r`, `fft_idata_i`  out  WIDTH  to pipeline input
- `fft_odata_en`  in  1  from pipeline `odata_en`
- `fft_odata_r`, `fft_odata_i`  in  WIDTH  from pipeline output
- `odata_en`  out  1  tagged output valid
- `odata_r`, `odata_i`  out  WIDTH  tagged output data
- `odata_ch`  out  1  channel owning the current output sample
- `odata_last`  out  1  last sample of an output frame
- `busy`  out  1  a frame is being issued, or at least one frame is in flight
- `err_orphan`  out  1  sticky: `fft_odata_en` seen while the tag FIFO is empty

## Operation
- FSM states: IDLE, ISSUE, GAP.
- IDLE → ISSUE when `req`≠0 and the tag FIFO is not full.
  - Winner: if only one `req` bit is set, that channel wins. If both are set, the channel pointed to by `rr_ptr` wins.
  - `rr_ptr` is reset to 0. It is set to the non-winner on every grant.
  - The winner's channel ID is pushed into the tag FIFO in the same cycle.
- ISSUE:
  - `grant[k]` stays high for exactly N cycles; the issue counter runs 0..N-1.
  - `req` is ignored during ISSUE; dropping `req` mid-frame does not shorten the frame.
- End of ISSUE (count = N-1):
  - If GAP>0, go to GAP for exactly GAP cycles, then IDLE.
  - If GAP=0 and the IDLE entry condition already holds, start the next frame on the next cycle with no bubble. This includes re-arbitration and the tag push.
- Input path: `fft_idata_*` are registered copies of the granted channel's data. `fft_idata_en` is a registered copy of `|grant`.
- Output path:
  - The output counter increments on each `fft_odata_en`.
  - At count N-1 the counter wraps to 0, `odata_last` is asserted, and the tag FIFO is popped.
  - `odata_*` are registered from `fft_*`. `odata_ch` is the FIFO head registered alongside the data.
  - `fft_odata_en` low mid-frame pauses the counter; it does not reset it.
- Push and pop in the same cycle with the FIFO full: legal. The occupancy stays the same.
- Orphan case: `fft_odata_en` with the FIFO empty sets `err_orphan`. `odata_ch` is 0 for that sample and the counter still advances. `err_orphan` clears only on reset.

## Timing
- Reset values: `grant`=0, `fft_idata_en`=0, `fft_idata_r`/`fft_idata_i`=0, `odata_en`=0, `odata_r`/`odata_i`=0, `odata_ch`=0, `odata_last`=0, `busy`=0, `err_orphan`=0. FSM is IDLE, `rr_ptr`=0, all counters 0, FIFO empty.
- `req` sampled at edge t (in IDLE) → `grant` high in cycles t+1..t+N → `fft_idata_en` high in cycles t+2..t+N+1.
- Input-to-pipeline latency: 1 cycle. Pipeline-output-to-`odata` latency: 1 cycle.
- `busy` = (state≠IDLE) or FIFO not empty, registered.
- Reset asserted mid-frame: all outputs return to their reset values asynchronously. Partially issued frames are discarded and not completed.

## Structure
- Package `fft_arb_pkg`:
  - state enum {IDLE, ISSUE, GAP}
  - `ch_id_t` (1 bit)
  - width helper `clog2`
- Sub-module `tag_fifo`: synchronous FIFO, width 1, depth `TAG_DEPTH`, with full/empty flags and simultaneous push/pop support.
- Counter widths are clog2(N) for the issue and output counters and clog2(GAP+1) for the gap counter.

## Test plan
- Single channel, N=16: `req`=01 held → `grant`=01 for 16 cycles; after the pipeline delay, 16 outputs with `odata_ch`=0 and `odata_last` on the 16th.
- Both requesting, GAP=0: grants alternate 0,1,0,1 with zero idle cycles between frames; the `odata_ch` sequence matches 0,1,0,1.
- TAG_DEPTH=2 with the pipeline output stalled: the third frame is not granted until the first `odata_last` pops the FIFO.
- GAP=3: exactly 3 cycles of `fft_idata_en`=0 between consecutive frames.
- `fft_odata_en` pulsed with no frames issued → `err_orphan`=1 and stays 1 until reset.
- Reset asserted at issue count 7 → `grant`=0 and `fft_idata_en`=0 immediately; after release, the next frame starts at count 0 with `rr_ptr`=0.

Source files
------------

// File: rtl/fft_arb_pkg.sv
// rtl/fft_arb_pkg.sv - shared types and helpers for the FFT frame arbiter
//
// Purpose: arbiter FSM state encoding, channel ID type and a width helper
// used by fft_frame_arbiter and tag_fifo.
// Ports: none (package).

package fft_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  typedef logic ch_id_t;

  // Bits needed to count 0..value-1; never less than 1 so that degenerate
  // parameters (e.g. a gap counter with GAP=0) still give a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/fft_frame_arbiter_tag_fifo.sv
// rtl/fft_frame_arbiter_tag_fifo.sv - in-flight channel tag FIFO
//
// Purpose: synchronous FIFO of 1-bit channel IDs, one entry per frame that
// has been issued into the FFT pipeline but not yet fully emitted.
// Ports:
//   clock, reset     clock and asynchronous active-low reset
//   push, push_data  enqueue a channel ID
//   pop              dequeue the head (ignored when empty)
//   head             current head entry
//   full, empty      occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.

module tag_fifo
  import fft_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  ch_id_t push_data,
  input  logic   pop,
  output ch_id_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_arbiter.sv
// rtl/fft_frame_arbiter.sv - round-robin frame arbiter in front of an SDF FFT
//
// Purpose: grants whole N-sample frames from two sources to one FFT pipeline,
// drives a contiguous idata_en burst per frame, and tags each pipeline output
// frame with the channel that produced it.
// Ports:
//   clock, reset                  clock, asynchronous active-low reset
//   req[1:0]                      per-channel "full frame ready"
//   grant[1:0]                    one-hot; granted channel streams a sample per cycle
//   ch0_data_r/i, ch1_data_r/i    channel samples
//   fft_idata_en, fft_idata_r/i   to pipeline input (registered)
//   fft_odata_en, fft_odata_r/i   from pipeline output
//   odata_en, odata_r/i           tagged output (registered)
//   odata_ch, odata_last          owning channel, last sample of frame
//   busy                          issuing or frames in flight
//   err_orphan                    sticky: pipeline output with no frame in flight

module fft_frame_arbiter
  import fft_arb_pkg::*;
#(
  parameter int N         = 64,
  parameter int WIDTH     = 16,
  parameter int GAP       = 0,
  parameter int TAG_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic [1:0]       grant,
  input  logic [WIDTH-1:0] ch0_data_r,
  input  logic [WIDTH-1:0] ch0_data_i,
  input  logic [WIDTH-1:0] ch1_data_r,
  input  logic [WIDTH-1:0] ch1_data_i,
  output logic             fft_idata_en,
  output logic [WIDTH-1:0] fft_idata_r,
  output logic [WIDTH-1:0] fft_idata_i,
  input  logic             fft_odata_en,
  input  logic [WIDTH-1:0] fft_odata_r,
  input  logic [WIDTH-1:0] fft_odata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i,
  output logic             odata_ch,
  output logic             odata_last,
  output logic             busy,
  output logic             err_orphan
);

  localparam int CW = clog2(N);
  localparam int GW = clog2(GAP + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [CW-1:0] icnt;
  logic [CW-1:0] icnt_nxt;
  logic [GW-1:0] gcnt;
  logic [GW-1:0] gcnt_nxt;
  ch_id_t        rr_ptr;
  ch_id_t        rr_nxt;
  ch_id_t        cur_ch;
  ch_id_t        cur_ch_nxt;
  ch_id_t        winner;
  logic          can_start;
  logic          start;

  logic [CW-1:0] ocnt;
  logic          out_wrap;

  ch_id_t        fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  // With a single requester it wins outright; with both, rr_ptr decides.
  // req=00 yields 0 here but can_start is low then, so it is never used.
  assign winner    = (req == 2'b11) ? rr_ptr : req[1];
  assign can_start = (req != 2'b00) && !fifo_full;
  assign out_wrap  = fft_odata_en && (ocnt == CNT_LAST);

  always_comb begin
    state_nxt  = state;
    icnt_nxt   = icnt;
    gcnt_nxt   = gcnt;
    rr_nxt     = rr_ptr;
    cur_ch_nxt = cur_ch;
    start      = 1'b0;

    case (state)
      ST_IDLE: begin
        start = can_start;
      end
      ST_ISSUE: begin
        if (icnt == CNT_LAST) begin
          if (GAP > 0) begin
            state_nxt = ST_GAP;
            gcnt_nxt  = '0;
          end else begin
            // Back-to-back: re-arbitrate on the last sample cycle.
            start = can_start;
            if (!can_start) state_nxt = ST_IDLE;
          end
        end else begin
          icnt_nxt = icnt + 1'b1;
        end
      end
      ST_GAP: begin
        // Arbitrating on the last gap cycle keeps the idle run at exactly GAP.
        if (gcnt == GAP_LAST) begin
          start = can_start;
          if (!can_start) state_nxt = ST_IDLE;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (start) begin
      state_nxt  = ST_ISSUE;
      icnt_nxt   = '0;
      cur_ch_nxt = winner;
      rr_nxt     = ~winner;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      icnt   <= '0;
      gcnt   <= '0;
      rr_ptr <= 1'b0;
      cur_ch <= 1'b0;
      grant  <= 2'b00;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      icnt   <= icnt_nxt;
      gcnt   <= gcnt_nxt;
      rr_ptr <= rr_nxt;
      cur_ch <= cur_ch_nxt;
      grant  <= (state_nxt == ST_ISSUE) ? {cur_ch_nxt, ~cur_ch_nxt} : 2'b00;
      busy   <= (state != ST_IDLE) || !fifo_empty;
    end
  end

  // Input path: one register stage between the granted source and the pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fft_idata_en <= 1'b0;
      fft_idata_r  <= '0;
      fft_idata_i  <= '0;
    end else begin
      fft_idata_en <= |grant;
      if (grant[1]) begin
        fft_idata_r <= ch1_data_r;
        fft_idata_i <= ch1_data_i;
      end else if (grant[0]) begin
        fft_idata_r <= ch0_data_r;
        fft_idata_i <= ch0_data_i;
      end else begin
        fft_idata_r <= '0;
        fft_idata_i <= '0;
      end
    end
  end

  // Output path: count samples per frame, tag with FIFO head, pop on wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ocnt       <= '0;
      odata_en   <= 1'b0;
      odata_r    <= '0;
      odata_i    <= '0;
      odata_ch   <= 1'b0;
      odata_last <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      odata_en   <= fft_odata_en;
      odata_r    <= fft_odata_r;
      odata_i    <= fft_odata_i;
      odata_last <= out_wrap;
      if (fft_odata_en) begin
        ocnt     <= (ocnt == CNT_LAST) ? '0 : ocnt + 1'b1;
        odata_ch <= fifo_empty ? 1'b0 : fifo_head;
        if (fifo_empty) err_orphan <= 1'b1;
      end
    end
  end

  tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (start),
    .push_data(winner),
    .pop      (out_wrap),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// tb/tb_fft_frame_arbiter.sv - self-checking bench for fft_frame_arbiter

module tb_fft_frame_arbiter;

  localparam int NA = 16;
  localparam int DA = 2;
  localparam int W  = 16;

  logic          clock;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    req_b;
  logic [W-1:0]  ch0_r, ch0_i, ch1_r, ch1_i;
  logic          fft_oen, fft_oen_b;
  logic [W-1:0]  fft_or, fft_oi;

  logic [1:0]    grant_a, grant_b;
  logic          ien_a, ien_b, oen_a, oen_b, och_a, och_b, olast_a, olast_b;
  logic          busy_a, busy_b, err_a, err_b;
  logic [W-1:0]  ir_a, ii_a, or_a, oi_a, ir_b, ii_b, or_b, oi_b;

  int n_vec = 0;
  int n_err = 0;

  // reference model state (frame-level view of the arbiter rules)
  bit  m_gon;
  int  m_ch, m_icnt, m_rr, m_ocnt;
  bit  m_err;
  int  m_tags[$];
  bit  drain;

  logic [1:0]   e_grant;
  logic         e_ien, e_oen, e_och, e_olast, e_busy, e_err;
  logic [W-1:0] e_ir, e_ii, e_or, e_oi;

  bit hist_b[128];
  int hcyc;

  fft_frame_arbiter #(.N(NA), .WIDTH(W), .GAP(0), .TAG_DEPTH(DA)) dut_a (
    .clock(clock), .reset(reset), .req(req), .grant(grant_a),
    .ch0_data_r(ch0_r), .ch0_data_i(ch0_i), .ch1_data_r(ch1_r), .ch1_data_i(ch1_i),
    .fft_idata_en(ien_a), .fft_idata_r(ir_a), .fft_idata_i(ii_a),
    .fft_odata_en(fft_oen), .fft_odata_r(fft_or), .fft_odata_i(fft_oi),
    .odata_en(oen_a), .odata_r(or_a), .odata_i(oi_a), .odata_ch(och_a),
    .odata_last(olast_a), .busy(busy_a), .err_orphan(err_a)
  );

  fft_frame_arbiter #(.N(NA), .WIDTH(W), .GAP(3), .TAG_DEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .grant(grant_b),
    .ch0_data_r(ch0_r), .ch0_data_i(ch0_i), .ch1_data_r(ch1_r), .ch1_data_i(ch1_i),
    .fft_idata_en(ien_b), .fft_idata_r(ir_b), .fft_idata_i(ii_b),
    .fft_odata_en(fft_oen_b), .fft_odata_r(fft_or), .fft_odata_i(fft_oi),
    .odata_en(oen_b), .odata_r(or_b), .odata_i(oi_b), .odata_ch(och_b),
    .odata_last(olast_b), .busy(busy_b), .err_orphan(err_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_gon = 0; m_ch = 0; m_icnt = 0; m_rr = 0; m_ocnt = 0; m_err = 0;
    m_tags.delete();
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_step();
    int  size0;
    bit  can, start;
    int  w;
    size0  = m_tags.size();
    e_busy = m_gon || (size0 > 0);
    e_ien  = m_gon;
    e_ir   = m_gon ? (m_ch ? ch1_r : ch0_r) : '0;
    e_ii   = m_gon ? (m_ch ? ch1_i : ch0_i) : '0;
    e_oen   = fft_oen;
    e_olast = 1'b0;
    if (fft_oen) begin
      e_or    = fft_or;
      e_oi    = fft_oi;
      e_och   = (size0 > 0) ? m_tags[0][0] : 1'b0;
      e_olast = (m_ocnt == NA - 1);
      if (size0 == 0) m_err = 1;
      m_ocnt = (m_ocnt + 1) % NA;
    end
    e_err = m_err;
    can = (req != 2'b00) && (size0 < DA);
    w = (req == 2'b11) ? m_rr : ((req == 2'b10) ? 1 : 0);
    start = 0;
    if (!m_gon) start = can;
    else if (m_icnt == NA - 1) begin
      m_gon = 0;
      start = can;
    end else m_icnt++;
    if (e_olast && size0 > 0) void'(m_tags.pop_front());
    if (start) begin
      m_gon = 1; m_ch = w; m_icnt = 0; m_rr = 1 - w;
      m_tags.push_back(w);
    end
    e_grant = m_gon ? (m_ch ? 2'b10 : 2'b01) : 2'b00;
  endfunction

  task automatic compare_all();
    check("grant", grant_a, e_grant);
    check("fft_idata_en", ien_a, e_ien);
    if (e_ien) begin
      check("fft_idata_r", ir_a, e_ir);
      check("fft_idata_i", ii_a, e_ii);
    end
    check("odata_en", oen_a, e_oen);
    check("odata_last", olast_a, e_olast);
    if (e_oen) begin
      check("odata_r", or_a, e_or);
      check("odata_i", oi_a, e_oi);
      check("odata_ch", och_a, e_och);
    end
    check("busy", busy_a, e_busy);
    check("err_orphan", err_a, e_err);
  endtask

  task automatic drive_inputs();
    ch0_r  = W'($urandom); ch0_i = W'($urandom);
    ch1_r  = W'($urandom); ch1_i = W'($urandom);
    fft_or = W'($urandom); fft_oi = W'($urandom);
    fft_oen = drain && ((m_tags.size() > 0) || (m_ocnt != 0)) && ($urandom_range(0, 3) != 0);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
    if (hcyc < 128) hist_b[hcyc] = ien_b;
    hcyc++;
    drive_inputs();
  endtask

  function automatic bit model_idle();
    return !m_gon && (m_tags.size() == 0) && (m_ocnt == 0);
  endfunction

  task automatic drain_to_idle(input string tag);
    int k;
    req = 2'b00;
    drain = 1;
    k = 0;
    while (!model_idle() && k < 400) begin
      step();
      k++;
    end
    check(tag, model_idle(), 1'b1);
    repeat (3) step();
  endtask

  initial begin
    reset = 1'b0; req = 2'b00; req_b = 2'b00; drain = 0;
    fft_oen = 1'b0; fft_oen_b = 1'b0; fft_or = '0; fft_oi = '0;
    ch0_r = '0; ch0_i = '0; ch1_r = '0; ch1_i = '0;
    hcyc = 0;
    model_reset();
    repeat (3) @(negedge clock);

    // reset values
    check("rst_grant", grant_a, 2'b00);
    check("rst_idata_en", ien_a, 1'b0);
    check("rst_idata_r", ir_a, '0);
    check("rst_odata_en", oen_a, 1'b0);
    check("rst_odata_r", or_a, '0);
    check("rst_odata_ch", och_a, 1'b0);
    check("rst_odata_last", olast_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_grant_b", grant_b, 2'b00);

    reset = 1'b1;
    req_b = 2'b01;

    // single channel, then drain
    req = 2'b01;
    repeat (40) step();
    drain_to_idle("drain_single");

    // both requesting, back-to-back alternation
    req = 2'b11; drain = 1;
    repeat (120) step();

    // output stalled: third frame must wait for a pop
    drain = 0;
    repeat (80) step();
    check("stall_no_grant", grant_a, 2'b00);
    drain = 1;
    repeat (60) step();

    // random requests and output stalls
    repeat (300) begin
      req = 2'($urandom_range(0, 3));
      drain = ($urandom_range(0, 3) != 0);
      step();
    end
    drain_to_idle("drain_random");
    check("idle_busy", busy_a, 1'b0);

    // reset in the middle of a frame at issue count 7
    begin
      int k;
      req = 2'b01;
      k = 0;
      while (!(m_gon && m_icnt == 7) && k < 50) begin
        step();
        k++;
      end
      check("reach_count7", (m_gon && m_icnt == 7), 1'b1);
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_grant", grant_a, 2'b00);
    check("midrst_idata_en", ien_a, 1'b0);
    check("midrst_busy", busy_a, 1'b0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    req = 2'b11;
    step();
    check("post_rst_grant_ch0", grant_a, 2'b01);
    repeat (40) step();
    drain_to_idle("drain_post_rst");

    // orphan pipeline output
    drain = 0;
    repeat (2) step();
    fft_oen = 1'b1;
    step();
    check("orphan_set", err_a, 1'b1);
    repeat (10) step();
    check("orphan_sticky", err_a, 1'b1);

    // GAP=3 instance: four frames of 16, exactly 3 idle cycles between, then full stall
    begin
      int p, r;
      p = 0;
      while (p < 128 && !hist_b[p]) p++;
      for (int f = 0; f < 4; f++) begin
        r = 0;
        while (p < 128 && hist_b[p]) begin r++; p++; end
        check($sformatf("gap_frame%0d_len", f), r, 16);
        r = 0;
        while (p < 128 && !hist_b[p]) begin r++; p++; end
        if (f < 3) check($sformatf("gap_idle%0d", f), r, 3);
        else check("gap_depth_stall", p, 128);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
